// File: rtl/pgm_sched_pkg.sv
// Shared definitions for the packet-generator transmit scheduler:
// table-entry field positions, packet header codes and FSM states.
package pgm_sched_pkg;

    localparam int unsigned ENTRY_W   = 138;
    localparam int unsigned DATA_W    = 134;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned TIME_W    = 64;

    localparam int unsigned START_MSB = 137;
    localparam int unsigned START_LSB = 74;
    localparam int unsigned RATE_MSB  = 73;
    localparam int unsigned RATE_LSB  = 10;
    localparam int unsigned ADDR_MSB  = 9;
    localparam int unsigned IDX_LSB   = 7;
    localparam int unsigned HDR_MSB   = 133;
    localparam int unsigned HDR_LSB   = 132;

    localparam logic [1:0] PKT_HEAD = 2'b01;
    localparam logic [1:0] PKT_TAIL = 2'b10;
    localparam logic [1:0] PKT_BODY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_READ,
        ST_DRAIN
    } pgm_state_t;

endpackage

// File: rtl/pgm_rr_arb.sv
// Round-robin arbiter: first requesting index at or above ptr, wrapping.
module pgm_rr_arb #(
    parameter int unsigned NUM_STREAMS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_STREAMS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_STREAMS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
            cand = ptr + IDX_W'(k);
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pgm_sched.sv
// Time-driven transmit scheduler: per-stream start/interval timers, round-robin
// grant of the stream-cache RAM read port, and in-order packet forwarding.
module pgm_sched
    import pgm_sched_pkg::*;
#(
    parameter int unsigned NUM_STREAMS   = 4,
    parameter int unsigned RAM_RD_LAT    = 1,
    parameter int unsigned MAX_PKT_WORDS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pgm_config_reset,
    input  logic                sent_ready,
    input  logic                table_entry_flag,
    input  logic [ENTRY_W-1:0]  table_entry_data,
    input  logic [TIME_W-1:0]   global_time,
    output logic                out_pgm_wr_raddr_wr,
    output logic [ADDR_W-1:0]   out_pgm_wr_raddr,
    input  logic [DATA_W-1:0]   in_pgm_wr_data,
    input  logic                in_pgm_data_ready,
    output logic                out_pgm_data_wr,
    output logic [DATA_W-1:0]   out_pgm_data
);

    localparam int unsigned IDX_W = $clog2(NUM_STREAMS);
    localparam int unsigned OFF_W = $clog2(MAX_PKT_WORDS);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MAX_PKT_WORDS - 1);

    pgm_state_t state, state_nxt;

    logic [NUM_STREAMS-1:0] valid;
    logic [TIME_W-1:0]      next_time [NUM_STREAMS];
    logic [TIME_W-1:0]      interval  [NUM_STREAMS];
    logic [ADDR_W-1:0]      base      [NUM_STREAMS];

    logic [NUM_STREAMS-1:0] elig, arb_grant;
    logic [IDX_W-1:0]       rr_ptr, arb_idx, cur, wr_idx;
    logic                   arb_vld;
    logic [OFF_W-1:0]       offset;
    logic                   stop_issue;
    logic [RAM_RD_LAT-1:0]  pipe_v, pipe_last;
    logic                   ret_v, ret_last, ret_tail;
    logic                   rd_en, grant_now;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            elig[i] = valid[i] && (global_time >= next_time[i]);
        end
    end

    pgm_rr_arb #(
        .NUM_STREAMS (NUM_STREAMS),
        .IDX_W       (IDX_W)
    ) u_arb (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign wr_idx   = table_entry_data[IDX_LSB +: IDX_W];
    assign ret_v    = pipe_v[RAM_RD_LAT-1];
    // pipe_last marks the word read at the final slot offset; it closes the packet
    assign ret_last = pipe_last[RAM_RD_LAT-1];
    assign ret_tail = ret_v && ((in_pgm_wr_data[HDR_MSB:HDR_LSB] == PKT_TAIL) || ret_last);

    assign out_pgm_wr_raddr_wr = rd_en;
    assign out_pgm_wr_raddr    = base[cur] + ADDR_W'(offset);

    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        rd_en     = 1'b0;
        if (pgm_config_reset) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (sent_ready) state_nxt = ST_ARB;
                ST_ARB: begin
                    if (!sent_ready) begin
                        state_nxt = ST_IDLE;
                    end else if (in_pgm_data_ready && arb_vld) begin
                        grant_now = 1'b1;
                        state_nxt = ST_READ;
                    end
                end
                ST_READ: begin
                    rd_en = !stop_issue && !ret_tail;
                    if (ret_tail) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_v == '0) state_nxt = sent_ready ? ST_ARB : ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            valid           <= '0;
            rr_ptr          <= '0;
            cur             <= '0;
            offset          <= '0;
            stop_issue      <= 1'b0;
            pipe_v          <= '0;
            pipe_last       <= '0;
            out_pgm_data_wr <= 1'b0;
            out_pgm_data    <= '0;
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                next_time[i] <= '0;
                interval[i]  <= '0;
                base[i]      <= '0;
            end
        end else begin
            state <= state_nxt;
            if (pgm_config_reset) begin
                valid           <= '0;
                rr_ptr          <= '0;
                stop_issue      <= 1'b0;
                pipe_v          <= '0;
                pipe_last       <= '0;
                out_pgm_data_wr <= 1'b0;
            end else begin
                pipe_v[0]    <= rd_en;
                pipe_last[0] <= rd_en && (offset == LAST_OFF);
                for (int unsigned k = 1; k < RAM_RD_LAT; k++) begin
                    pipe_v[k]    <= pipe_v[k-1];
                    pipe_last[k] <= pipe_last[k-1];
                end

                out_pgm_data_wr <= (state == ST_READ) && ret_v;
                if ((state == ST_READ) && ret_v) begin
                    out_pgm_data <= ret_last ? {PKT_TAIL, in_pgm_wr_data[HDR_LSB-1:0]}
                                             : in_pgm_wr_data;
                end

                if (rd_en) begin
                    offset <= offset + OFF_W'(1);
                    if (offset == LAST_OFF) stop_issue <= 1'b1;
                end

                if (grant_now) begin
                    cur                <= arb_idx;
                    rr_ptr             <= arb_idx + IDX_W'(1);
                    offset             <= '0;
                    stop_issue         <= 1'b0;
                    next_time[arb_idx] <= next_time[arb_idx] + interval[arb_idx];
                    if (interval[arb_idx] == '0) valid <= valid & ~arb_grant;
                end

                // Later non-blocking writes win, so a table write overrides a same-cycle grant update
                if (table_entry_flag) begin
                    valid[wr_idx]     <= 1'b1;
                    next_time[wr_idx] <= table_entry_data[START_MSB:START_LSB];
                    interval[wr_idx]  <= table_entry_data[RATE_MSB:RATE_LSB];
                    base[wr_idx]      <= table_entry_data[ADDR_MSB:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pgm_sched.sv
// Self-checking bench for pgm_sched: acts as the stream-cache RAM and compares
// every forwarded word against a packet-level model of the scheduling rules.
module tb_pgm_sched;

    localparam int unsigned LAT  = 1;
    localparam int unsigned MAXW = 128;
    localparam logic [1:0] H_HEAD = 2'b01;
    localparam logic [1:0] H_TAIL = 2'b10;
    localparam logic [1:0] H_BODY = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pgm_config_reset = 1'b0;
    logic         sent_ready = 1'b0;
    logic         table_entry_flag = 1'b0;
    logic [137:0] table_entry_data = '0;
    logic [63:0]  global_time = '0;
    logic         rd;
    logic [9:0]   raddr;
    logic [133:0] rdata;
    logic         ready;
    logic         wr;
    logic [133:0] odata;

    always #5 clk = ~clk;

    pgm_sched #(
        .NUM_STREAMS   (4),
        .RAM_RD_LAT    (LAT),
        .MAX_PKT_WORDS (MAXW)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pgm_config_reset    (pgm_config_reset),
        .sent_ready          (sent_ready),
        .table_entry_flag    (table_entry_flag),
        .table_entry_data    (table_entry_data),
        .global_time         (global_time),
        .out_pgm_wr_raddr_wr (rd),
        .out_pgm_wr_raddr    (raddr),
        .in_pgm_wr_data      (rdata),
        .in_pgm_data_ready   (ready),
        .out_pgm_data_wr     (wr),
        .out_pgm_data        (odata)
    );

    // RAM: header per address, payload carries the address it was read from
    logic [1:0] ram_hdr [1024];
    logic [9:0] addr_q = '0;
    always @(posedge clk) addr_q <= raddr;
    assign rdata = {ram_hdr[addr_q], 122'd0, addr_q};

    logic rand_ready = 1'b0, ready_force = 1'b0, rnd_bit = 1'b1;
    always @(negedge clk) rnd_bit <= ($urandom_range(3) != 0);
    assign ready = rand_ready ? rnd_bit : ready_force;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];
    int          cyc = 0;
    int          rd_total = 0;
    logic        h_rd   [8];
    logic [9:0]  h_addr [8];

    always @(negedge clk) begin
        int li;
        h_rd[cyc % 8]   = rd;
        h_addr[cyc % 8] = raddr;
        if (rd) rd_total++;
        if (wr) begin
            got_q.push_back({odata[133:132], odata[9:0]});
            if (cyc >= int'(LAT) + 1) begin
                li = (cyc - int'(LAT) - 1) % 8;
                chk("rd_to_out", {53'd0, h_rd[li], h_addr[li]}, {53'd0, 1'b1, odata[9:0]});
            end
        end
        cyc++;
    end

    logic        m_valid [4];
    logic [63:0] m_next  [4];
    logic [63:0] m_int   [4];
    logic [9:0]  m_base  [4];
    int          m_rr;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_pkt(input logic [9:0] b, input int len);
        for (int k = 0; k < len; k++) begin
            ram_hdr[b + 10'(k)] = (k == 0) ? H_HEAD : (k == len - 1) ? H_TAIL : H_BODY;
        end
    endtask

    task automatic write_entry(input logic [63:0] start, input logic [63:0] intv, input logic [9:0] b);
        int i;
        @(negedge clk);
        table_entry_flag = 1'b1;
        table_entry_data = {start, intv, b};
        @(negedge clk);
        table_entry_flag = 1'b0;
        i = int'(b[8:7]);
        m_valid[i] = 1'b1;
        m_next[i]  = start;
        m_int[i]   = intv;
        m_base[i]  = b;
    endtask

    task automatic cfg_reset();
        @(negedge clk);
        pgm_config_reset = 1'b1;
        @(negedge clk);
        pgm_config_reset = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    // Everything eligible at frozen time t goes out, one whole packet per grant
    task automatic model_send(input logic [63:0] t);
        int s, found;
        logic [9:0] a;
        logic [1:0] h;
        for (int n = 0; n < 200; n++) begin
            found = -1;
            for (int k = 0; k < 4; k++) begin
                s = (m_rr + k) % 4;
                if (found < 0 && m_valid[s] && t >= m_next[s]) found = s;
            end
            if (found < 0) break;
            for (int k = 0; k < int'(MAXW); k++) begin
                a = m_base[found] + 10'(k);
                h = (k == int'(MAXW) - 1) ? H_TAIL : ram_hdr[a];
                exp_q.push_back({h, a});
                if (h == H_TAIL) break;
            end
            m_rr = (found + 1) % 4;
            m_next[found] = m_next[found] + m_int[found];
            if (m_int[found] == 64'd0) m_valid[found] = 1'b0;
        end
    endtask

    task automatic settle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 40 && n < 4000) begin
            @(negedge clk);
            n++;
            if (rd || wr) quiet = 0;
            else quiet++;
        end
        chk({tag, "_settled"}, 64'(n < 4000), 64'd1);
    endtask

    task automatic cmp(input string tag);
        int m;
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic step(input logic [63:0] t, input string tag);
        global_time = t;
        model_send(t);
        settle(tag);
        cmp(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] t1_hdr [4];
        int k, rd_base, off, len;
        logic [9:0] b;
        logic [63:0] tt, st, iv;

        t1_hdr = '{H_HEAD, H_BODY, H_BODY, H_TAIL};
        for (int i = 0; i < 1024; i++) ram_hdr[i] = H_BODY;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_rr = 0;

        tick(3);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_raddr", 64'(raddr), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_data", 64'(|odata), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single stream: not before start time, then 4-word packet, next at 1100
        fill_pkt(10'h000, 4);
        write_entry(64'd100, 64'd1000, 10'h000);
        global_time = 64'd50;
        ready_force = 1'b1;
        sent_ready  = 1'b1;
        rd_base = rd_total;
        tick(20);
        chk("t1_early_rd", 64'(rd_total - rd_base), 64'd0);
        global_time = 64'd100;
        model_send(64'd100);
        settle("t1_pkt");
        chk("t1_words", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("t1_hdr", 64'(got_q[i][11:10]), 64'(t1_hdr[i]));
        cmp("t1_pkt");
        step(64'd1099, "t1_1099");
        step(64'd1100, "t1_1100");

        // Four streams, same start/interval: round-robin order and pointer wrap
        cfg_reset();
        sent_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fill_pkt(10'(i * 128), 3);
            write_entry(64'd0, 64'd500, 10'(i * 128));
        end
        global_time = 64'd0;
        sent_ready = 1'b1;
        step(64'd0, "t2_first");
        step(64'd499, "t2_499");
        step(64'd500, "t2_500");

        // Downstream not ready: no reads until ready rises, then grant at once
        cfg_reset();
        sent_ready = 1'b0;
        fill_pkt(10'h080, 5);
        write_entry(64'd300, 64'd10000, 10'h080);
        global_time = 64'd0;
        ready_force = 1'b0;
        sent_ready = 1'b1;
        tick(2);
        global_time = 64'd300;
        rd_base = rd_total;
        tick(20);
        chk("t3_noready_rd", 64'(rd_total - rd_base), 64'd0);
        ready_force = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rd && k < 10);
        chk("t3_grant_lat", 64'(k), 64'd1);
        model_send(64'd300);
        settle("t3_pkt");
        cmp("t3_pkt");

        // Slot with no tail: truncated at MAXW words with forced tail
        cfg_reset();
        sent_ready = 1'b0;
        for (int i = 0; i <= 128; i++) ram_hdr[10'h200 + 10'(i)] = (i == 0) ? H_HEAD : H_BODY;
        write_entry(64'd0, 64'd5000, 10'h200);
        global_time = 64'd1;
        sent_ready = 1'b1;
        model_send(64'd1);
        settle("t4_trunc");
        chk("t4_len_exact", 64'(got_q.size()), 64'd128);
        if (got_q.size() == 128) chk("t4_last_hdr", 64'(got_q[127][11:10]), 64'(H_TAIL));
        cmp("t4_trunc");

        // One-shot stream, then re-armed by a fresh table write
        cfg_reset();
        sent_ready = 1'b0;
        fill_pkt(10'h100, 3);
        write_entry(64'd200, 64'd0, 10'h100);
        global_time = 64'd200;
        sent_ready = 1'b1;
        step(64'd200, "t5_once");
        step(64'd5000, "t5_none");
        step(64'd100000, "t5_none2");
        write_entry(64'd100500, 64'd0, 10'h100);
        step(64'd100500, "t5_rearm");

        // Config reset mid-packet: output stops next cycle, stream cleared
        cfg_reset();
        sent_ready = 1'b0;
        fill_pkt(10'h300, 6);
        write_entry(64'd10, 64'd1000, 10'h300);
        global_time = 64'd10;
        sent_ready = 1'b1;
        model_send(64'd10);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (got_q.size() < 2 && k < 300);
        chk("t6_seen2", 64'(got_q.size() >= 2), 64'd1);
        pgm_config_reset = 1'b1;
        @(posedge clk);
        #1;
        pgm_config_reset = 1'b0;
        chk("t6_rd_off", 64'(rd), 64'd0);
        chk("t6_wr_off", 64'(wr), 64'd0);
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        tick(60);
        cmp("t6_cut");
        step(64'd1500, "t6_idle");
        write_entry(64'd2000, 64'd1000, 10'h300);
        step(64'd2000, "t6_new");

        // Randomized streams and time steps, ready toggling randomly
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            cfg_reset();
            sent_ready = 1'b0;
            global_time = 64'd0;
            for (int i = 0; i < 4; i++) begin
                off = $urandom_range(100);
                len = $urandom_range(10, 2);
                b = {1'($urandom_range(1)), 2'(i), 7'(off)};
                fill_pkt(b, len);
                st = 64'($urandom_range(3000));
                iv = ($urandom_range(4) == 0) ? 64'd0 : 64'($urandom_range(1500, 200));
                write_entry(st, iv, b);
            end
            sent_ready = 1'b1;
            tt = 64'd0;
            while (tt < 64'd6000) begin
                tt = tt + 64'($urandom_range(600, 50));
                step(tt, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pgm_sched.md
Name: pgm_sched

Overview:
- Time-driven transmit scheduler for the packet-generator path.
- Holds up to four stream entries, each with start time, send interval and RAM base address.
- When a stream's next send time is reached, it sequences word reads from the stream-cache RAM and emits the packet to the downstream output port.
- Round-robin arbitration shares the single RAM read port between eligible streams.

Parameters:
- NUM_STREAMS, 4, number of schedulable streams (index = entry bits [8:7]).
- RAM_RD_LAT, 1, cycles from read-enable to valid RAM data (1..2).
- MAX_PKT_WORDS, 128, maximum words per packet (slot size in RAM).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- pgm_config_reset  in  1  1 = configuration mode: clear all streams, stop output.
- sent_ready  in  1  1 = all stream packets cached; scheduling enabled.
- table_entry_flag  in  1  one-cycle strobe: table_entry_data valid.
- table_entry_data  in  138  [137:74] start time, [73:10] interval, [9:0] RAM base address.
- global_time  in  64  free-running time counter (same units as start/interval).
- out_pgm_wr_raddr_wr  out  1  RAM read enable.
- out_pgm_wr_raddr  out  10  RAM read address.
- in_pgm_wr_data  in  134  RAM read data; [133:132] 01 = head, 10 = tail, 11 = middle.
- in_pgm_data_ready  in  1  downstream can accept a whole packet.
- out_pgm_data_wr  out  1  output word valid.
- out_pgm_data  out  134  output word.

Behaviour:
- Reset: all outputs 0; valid[], next_time[], interval[], base[] = 0; rr_ptr = 0; FSM = IDLE.
- Table write (table_entry_flag = 1, pgm_config_reset = 0):
  - i = data[8:7]; valid[i] <= 1; next_time[i] <= data[137:74]; interval[i] <= data[73:10]; base[i] <= data[9:0].
  - A same-cycle grant update to stream i loses to the table write.
- Eligibility: valid[i] && global_time >= next_time[i] (64-bit unsigned compare).
- FSM:
  - IDLE: go to ARB when sent_ready = 1 and pgm_config_reset = 0.
  - ARB: if in_pgm_data_ready and any stream eligible, grant the first eligible index from rr_ptr upward (wrapping).
    - Set rr_ptr <= g+1 (mod NUM_STREAMS); offset <= 0.
    - next_time[g] <= next_time[g] + interval[g] (64-bit, wraps modulo 2^64).
    - If interval[g] = 0: one-shot, valid[g] <= 0.
    - Go to READ.
    - With no eligible stream, stay in ARB.
  - READ: each cycle, out_pgm_wr_raddr_wr = 1 and out_pgm_wr_raddr = base[g] + offset; offset++.
    - Returned data appears RAM_RD_LAT cycles later.
    - Forward it as out_pgm_data / out_pgm_data_wr = 1, registered: one cycle after RAM data.
    - On returned word with [133:132] = 10: forward it, stop issuing reads, go to DRAIN.
    - If offset reaches MAX_PKT_WORDS-1 without a tail: that word is forwarded with [133:132] forced to 10, then go to DRAIN.
  - DRAIN: reads issued after the tail are speculative. Their returned data is discarded (out_pgm_data_wr = 0). Wait until no read is outstanding, then go to ARB.
- Address latency: grant-to-first output word = RAM_RD_LAT + 1 cycles after the first read.
- Packets are never interleaved. in_pgm_data_ready is sampled only in ARB; it is ignored mid-packet.
- sent_ready falling mid-packet: the packet completes, then FSM returns to IDLE.
- pgm_config_reset = 1, any state:
  - Next cycle: FSM = IDLE; out_pgm_wr_raddr_wr = 0; out_pgm_data_wr = 0; all valid[] = 0; rr_ptr = 0.
  - A truncated packet gets no tail.
  - Table writes are ignored while it is asserted.
- Data values are not checked except bits [133:132].

Decomposition:
- Shared package:
  - entry field bit positions (START_MSB = 137, START_LSB = 74, RATE_MSB = 73, RATE_LSB = 10, ADDR_MSB = 9).
  - header codes PKT_HEAD = 2'b01, PKT_TAIL = 2'b10, PKT_BODY = 2'b11.
  - FSM state encodings.
- One sub-module: pgm_rr_arb (NUM_STREAMS-bit request vector + pointer -> one-hot grant and index).
- Timer compare/update stays inline.

Test Plan:
- Write stream 0 (start = 100, interval = 1000, base = 0x000), RAM holds a 4-word packet, sent_ready = 1 -> reads at 0x000..0x003 beginning when global_time ≥ 100; out_pgm_data_wr high exactly 4 cycles, headers 01,11,11,10; next send at time 1100.
- Streams 0..3 all start = 0, interval = 500 -> output packet order 0,1,2,3 then 0,1,2,3 from t = 500; no interleaving; rr_ptr wraps 3 -> 0.
- in_pgm_data_ready = 0 while stream 1 is eligible -> no reads; raise ready at t = 300 -> grant within 1 cycle.
- RAM slot with no tail in 128 words -> exactly 128 output words, last with [133:132] = 10; FSM returns to ARB.
- Stream 2 with interval = 0 -> sent once, never again; re-writing the entry re-arms it.
- pgm_config_reset pulse on word 2 of a 6-word packet -> next cycle out_pgm_data_wr = 0 and out_pgm_wr_raddr_wr = 0; no further output until new entries are written and sent_ready = 1.
